sdiv_iter: RTL and testbench

Iterative signed fixed-point divider; the inverse counterpart of the team's combinational signed fixed-point multiplier. It accepts a signed Q(WI1.WF1) dividend and a signed Q(WI2.WF2) divisor and returns a signed Q(WIO.WFO) quotient. It uses a one-bit-per-cycle restoring algorithm with a start/valid handshake. It sits in the ALU datapath beside the multiplier and shares its operand format parameters.

---
 rtl/sdiv_iter_if.sv | 18 +
 rtl/sdiv_iter.sv | 135 +++++++++++++
 tb/tb_sdiv_iter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sdiv_iter_if.sv
// Request/result bundle for the iterative signed fixed-point divider.
interface sdiv_iter_if #(
   parameter int unsigned W1 = 7,
   parameter int unsigned W2 = 7,
   parameter int unsigned WO = 12
);
   logic          start;
   logic [W1-1:0] in1;
   logic [W2-1:0] in2;
   logic          busy;
   logic          valid;
   logic [WO-1:0] out;
   logic          ovf;
   logic          dz;

   modport master (output start, in1, in2, input busy, valid, out, ovf, dz);
   modport slave  (input start, in1, in2, output busy, valid, out, ovf, dz);
endinterface

// File: rtl/sdiv_iter.sv
// Restoring signed fixed-point divider, one quotient bit per cycle, start/valid handshake.
// Define SDIV_SAT_EN to saturate the quotient on overflow instead of wrapping.
module sdiv_iter #(
   parameter int unsigned WI1 = 4,
   parameter int unsigned WF1 = 3,
   parameter int unsigned WI2 = 2,
   parameter int unsigned WF2 = 5,
   parameter int unsigned WIO = 4,
   parameter int unsigned WFO = 8
) (
   input  logic          CLK,
   input  logic          RST,
   sdiv_iter_if.slave    bus
);
   localparam int unsigned W1 = WI1 + WF1;
   localparam int unsigned W2 = WI2 + WF2;
   localparam int unsigned WO = WIO + WFO;
   localparam int unsigned N  = WI1 + WFO + WF2;
   localparam int unsigned SH = WFO + WF2 - WF1;
   localparam int unsigned CW = $clog2(N + 1);

   localparam logic [WO-1:0] MOST_POS = {1'b0, {(WO-1){1'b1}}};
   localparam logic [WO-1:0] MOST_NEG = {1'b1, {(WO-1){1'b0}}};
   localparam logic [31:0]   POS_LIM  = 32'(2**(WO-1) - 1);
   localparam logic [31:0]   NEG_LIM  = 32'(2**(WO-1));

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [N-1:0]  nq;      // numerator bits leave at the MSB, quotient bits enter at the LSB
   logic [W2-1:0] rem;
   logic [W2-1:0] den;
   logic [CW-1:0] cnt;
   logic          neg;
   logic          neg1;

   logic [W1-1:0]    mag1_c;
   logic [W2-1:0]    mag2_c;
   logic [W2:0]      shl_c;
   logic [W2:0]      trial_c;
   logic signed [N:0] sres_c;
   logic             ovf_c;

   // Operand magnitudes; the most negative code maps onto its unsigned magnitude.
   always_comb begin
      mag1_c = bus.in1[W1-1] ? (~bus.in1 + W1'(1)) : bus.in1;
      mag2_c = bus.in2[W2-1] ? (~bus.in2 + W2'(1)) : bus.in2;
   end

   // Trial subtraction; the top bit of trial_c is the borrow.
   always_comb begin
      shl_c   = {rem, nq[N-1]};
      trial_c = shl_c - {1'b0, den};
   end

   // Signed quotient and range check, valid once all iterations are done.
   always_comb begin
      sres_c = neg ? -$signed({1'b0, nq}) : $signed({1'b0, nq});
      ovf_c  = neg ? (32'(nq) > NEG_LIM) : (32'(nq) > POS_LIM);
   end

   always_ff @(posedge CLK) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CALC;
         CALC:    if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         nq        <= '0;
         rem       <= '0;
         den       <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         neg1      <= 1'b0;
         bus.busy  <= 1'b0;
         bus.valid <= 1'b0;
         bus.out   <= '0;
         bus.ovf   <= 1'b0;
         bus.dz    <= 1'b0;
      end else begin
         bus.valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  nq       <= N'(mag1_c) << SH;
                  rem      <= '0;
                  den      <= mag2_c;
                  neg      <= bus.in1[W1-1] ^ bus.in2[W2-1];
                  neg1     <= bus.in1[W1-1];
                  cnt      <= CW'(N);
                  bus.busy <= 1'b1;
               end
            end
            CALC: begin
               nq  <= {nq[N-2:0], ~trial_c[W2]};
               rem <= trial_c[W2] ? shl_c[W2-1:0] : trial_c[W2-1:0];
               cnt <= cnt - CW'(1);
            end
            DONE: begin
               bus.busy  <= 1'b0;
               bus.valid <= 1'b1;
               if (den == '0) begin
                  // Quotient register holds garbage here; the code follows the dividend sign.
                  bus.out <= neg1 ? MOST_NEG : MOST_POS;
                  bus.ovf <= 1'b0;
                  bus.dz  <= 1'b1;
               end else begin
                  bus.ovf <= ovf_c;
                  bus.dz  <= 1'b0;
`ifdef SDIV_SAT_EN
                  if (ovf_c) bus.out <= neg ? MOST_NEG : MOST_POS;
                  else       bus.out <= WO'(sres_c);
`else
                  bus.out <= WO'(sres_c);
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sdiv_iter.sv
// Scoreboard bench for sdiv_iter: arithmetic reference model, timing-level protocol model, negedge monitor.
module tb_sdiv_iter;
   localparam int unsigned WI1 = 4, WF1 = 3, WI2 = 2, WF2 = 5, WIO = 4, WFO = 8;
   localparam int unsigned W1 = WI1 + WF1;
   localparam int unsigned W2 = WI2 + WF2;
   localparam int unsigned WO = WIO + WFO;
   localparam int unsigned N  = WI1 + WFO + WF2;
   localparam longint SCALE = longint'(1) << (WFO + WF2 - WF1);
   localparam longint OMAX  = (longint'(1) << (WO - 1)) - 1;
   localparam longint OMIN  = -(longint'(1) << (WO - 1));

   typedef struct {
      logic [WO-1:0] out;
      logic          ovf;
      logic          dz;
      int            due;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   sdiv_iter_if #(.W1(W1), .W2(W2), .WO(WO)) bus ();

   sdiv_iter #(.WI1(WI1), .WF1(WF1), .WI2(WI2), .WF2(WF2), .WIO(WIO), .WFO(WFO)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   exp_t          q[$];
   int            cyc      = 0;
   int            free_at  = 0;
   int            busy_end = 0;
   logic          e_valid  = 1'b0;
   logic [WO-1:0] e_out    = '0;
   logic          e_ovf    = 1'b0;
   logic          e_dz     = 1'b0;
   int            n_cmp    = 0;
   int            n_err    = 0;

   // Quotient from plain signed arithmetic: (in1 * 2^(WFO+WF2-WF1)) / in2, truncated toward zero.
   function automatic exp_t ref_div(input logic [W1-1:0] a, input logic [W2-1:0] b, input int due);
      exp_t   r;
      longint sa, sb, qv;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      r.due = due;
      r.ovf = 1'b0;
      r.dz  = 1'b0;
      if (sb == 0) begin
         r.dz  = 1'b1;
         r.out = (sa >= 0) ? WO'(OMAX) : WO'(OMIN);
      end else begin
         qv    = (sa * SCALE) / sb;
         r.ovf = (qv > OMAX) || (qv < OMIN);
`ifdef SDIV_SAT_EN
         if (r.ovf) qv = (qv > 0) ? OMAX : OMIN;
`endif
         r.out = WO'(qv);
      end
      return r;
   endfunction

   // Protocol model: accept when free, result N+1 edges later, next accept N+2 edges later.
   always @(posedge CLK) begin
      exp_t e;
      cyc = cyc + 1;
      if (!RST) begin
         q.delete();
         free_at  = 0;
         busy_end = 0;
         e_valid  = 1'b0;
         e_out    = '0;
         e_ovf    = 1'b0;
         e_dz     = 1'b0;
      end else begin
         e_valid = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            e       = q.pop_front();
            e_out   = e.out;
            e_ovf   = e.ovf;
            e_dz    = e.dz;
            e_valid = 1'b1;
         end
         if (bus.start && cyc >= free_at) begin
            q.push_back(ref_div(bus.in1, bus.in2, cyc + int'(N) + 1));
            free_at  = cyc + int'(N) + 2;
            busy_end = cyc + int'(N) + 1;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (cyc >= 1) begin
         check("valid", 32'(bus.valid), 32'(e_valid));
         check("busy",  32'(bus.busy),  32'(cyc < busy_end));
         check("out",   32'(bus.out),   32'(e_out));
         check("ovf",   32'(bus.ovf),   32'(e_ovf));
         check("dz",    32'(bus.dz),    32'(e_dz));
      end
   end

   task automatic wait_free();
      int guard;
      guard = 0;
      while (cyc + 1 < free_at) begin
         @(negedge CLK);
         guard++;
         if (guard > 200) begin
            $display("FAIL wait_free: bench stalled at cycle %0d", cyc);
            $fatal(1, "bench stalled");
         end
      end
   endtask

   // One start pulse; operands are scrambled afterwards to show capture-only-at-accept.
   task automatic issue(input logic [W1-1:0] a, input logic [W2-1:0] b);
      @(negedge CLK);
      wait_free();
      bus.start = 1'b1;
      bus.in1   = a;
      bus.in2   = b;
      @(negedge CLK);
      bus.start = 1'b0;
      bus.in1   = W1'($urandom);
      bus.in2   = W2'($urandom);
   endtask

   initial begin
      logic [W1-1:0] a;
      logic [W2-1:0] b;
      int            guard;
      bus.start = 1'b0;
      bus.in1   = '0;
      bus.in2   = '0;
      RST       = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;

      issue(7'h1C, 7'h28);
      issue(7'h64, 7'h28);
      issue(7'h64, 7'h58);
      issue(7'h3F, 7'h01);
      issue(7'h1C, 7'h00);
      issue(7'h64, 7'h00);
      issue(7'h40, 7'h40);
      issue(7'h40, 7'h01);
      issue(7'h00, 7'h00);

      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         a = W1'($urandom);
         b = ($urandom_range(0, 5) == 0) ? '0 : W2'($urandom);
         issue(a, b);
      end

      // Start held high with operands changing every cycle.
      @(negedge CLK);
      wait_free();
      bus.start = 1'b1;
      repeat (4 * (N + 2) + 2) begin
         bus.in1 = W1'($urandom);
         bus.in2 = W2'($urandom);
         @(negedge CLK);
      end
      bus.start = 1'b0;

      // Reset on the 8th CALC edge aborts the in-flight division.
      issue(7'h1C, 7'h28);
      repeat (7) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      issue(7'h1C, 7'h28);
      issue(7'h64, 7'h58);

      guard = 0;
      while (q.size() > 0 || cyc < busy_end) begin
         @(negedge CLK);
         guard++;
         if (guard > 200) begin
            $display("FAIL drain: results still pending at cycle %0d", cyc);
            $fatal(1, "drain stalled");
         end
      end
      repeat (3) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
